// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, default operand width and counter-width helper for mul_seq_nbit
package mul_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W = $clog2(WIDTH_DEF + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mul_seq_nbit_if.sv
// mul_seq_nbit_if: multiplier handshake bundle; master drives start/A/B, slave drives busy/done/P
interface mul_seq_nbit_if #(parameter int WIDTH = mul_pkg::WIDTH_DEF);
  logic start;
  logic [WIDTH-1:0] A, B;
  logic busy, done;
  logic [2*WIDTH-1:0] P;
  modport master (output start, A, B, input busy, done, P);
  modport slave (input start, A, B, output busy, done, P);
endinterface

// File: rtl/mul_acc_adder.sv
// mul_acc_adder: combinational WIDTH-bit ripple adder, ports a/b in, sum and carry-out co out
module mul_acc_adder #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic c;
  always_comb begin
    c = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

// File: rtl/mul_seq_nbit.sv
// mul_seq_nbit: shift-and-add multiplier, clk/rst_n plus slave bus (start,A,B -> busy,done,P); MUL_SIGNED_EN enables two's complement
module mul_seq_nbit
  import mul_pkg::*;
#(parameter int WIDTH = WIDTH_DEF) (
  input logic          clk,
  input logic          rst_n,
  mul_seq_nbit_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, hi, sum, a_in, b_in;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx, p_q, p_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic co, accept;
  assign hi = acc_q[2*WIDTH-1:WIDTH];
  mul_acc_adder #(.WIDTH(WIDTH)) u_add (.a(hi), .b(mcand_q), .sum(sum), .co(co));
  assign acc_nx = acc_q[0] ? {co, sum, acc_q[WIDTH-1:1]} : {1'b0, hi, acc_q[WIDTH-1:1]};
  assign accept = (state_q != CALC) && bus.start;
`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;
  assign a_in = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign b_in = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign neg_d = accept ? bus.A[WIDTH-1] ^ bus.B[WIDTH-1] : neg_q;
  assign res = neg_q ? -acc_nx : acc_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) neg_q <= 1'b0;
    else neg_q <= neg_d;
`else
  assign a_in = bus.A;
  assign b_in = bus.B;
  assign res = acc_nx;
`endif
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d = p_q;
    if (state_q == CALC) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        p_d = res;
      end
    end else if (accept) begin
      state_d = CALC;
      mcand_d = a_in;
      acc_d = {{WIDTH{1'b0}}, b_in};
      cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
    end
  assign bus.busy = state_q == CALC;
  assign bus.done = state_q == DONE;
  assign bus.P = p_q;
endmodule

// File: tb/tb_mul_seq_nbit.sv
// tb_mul_seq_nbit: directed self-checking bench for mul_seq_nbit at WIDTH=4
module tb_mul_seq_nbit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tot = 0;
  int n_bad = 0;
  mul_seq_nbit_if #(.WIDTH(W)) bus ();
  mul_seq_nbit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output logic [7:0] p, output int lat, output int nb);
    bit hit = 0;
    lat = 0;
    nb = 0;
    p = '0;
    for (int i = 1; i <= 20; i++) begin
      if (!hit) begin
        nb += int'(bus.busy);
        @(posedge clk);
        #1;
        if (bus.done) begin
          hit = 1;
          lat = i;
          p = bus.P;
        end
      end
    end
    if (!hit) chk("timeout", 0, 1);
  endtask
  task automatic mul(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p, output int lat, output int nb);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    wait_done(p, lat, nb);
  endtask
  initial begin
    logic [7:0] p;
    int lat, nb, cnt;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_p", 32'(bus.P), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef MUL_SIGNED_EN
    mul(4'h8, 4'h8, p, lat, nb);
    chk("s_m8m8", 32'(p), 32'h40);
    chk("s_lat", 32'(lat), W);
    mul(4'h8, 4'h7, p, lat, nb);
    chk("s_m8p7", 32'(p), 32'hC8);
    mul(4'hF, 4'h1, p, lat, nb);
    chk("s_m1p1", 32'(p), 32'hFF);
    mul(4'h3, 4'hE, p, lat, nb);
    chk("s_3m2", 32'(p), 32'hFA);
`else
    mul(4'd15, 4'd15, p, lat, nb);
    chk("max_p", 32'(p), 32'hE1);
    chk("max_lat", 32'(lat), W);
    chk("max_busy", 32'(nb), W);
    @(posedge clk);
    #1;
    chk("done_drop", 32'(bus.done), 0);
    chk("p_hold", 32'(bus.P), 32'hE1);
    mul(4'd0, 4'd9, p, lat, nb);
    chk("zero_a", 32'(p), 0);
    chk("zero_a_lat", 32'(lat), W);
    mul(4'd9, 4'd0, p, lat, nb);
    chk("zero_b", 32'(p), 0);
    chk("zero_b_lat", 32'(lat), W);
    bus.start = 1'b1;
    bus.A = 4'd6;
    bus.B = 4'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("calc_p_hold", 32'(bus.P), 0);
    bus.start = 1'b1;
    bus.A = 4'd1;
    bus.B = 4'd1;
    wait_done(p, lat, nb);
    chk("ign_p", 32'(p), 32'h2A);
    chk("ign_lat", 32'(lat), W - 1);
    bus.A = 4'd3;
    bus.B = 4'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_hold", 32'(bus.P), 32'h2A);
    wait_done(p, lat, nb);
    chk("b2b_p", 32'(p), 32'h0F);
    chk("b2b_lat", 32'(lat), W);
    bus.start = 1'b1;
    bus.A = 4'd13;
    bus.B = 4'd11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_p", 32'(bus.P), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      cnt += int'(bus.done) + int'(bus.busy);
    end
    chk("abort_quiet", 32'(cnt), 0);
    mul(4'd2, 4'd3, p, lat, nb);
    chk("after_rst", 32'(p), 32'h06);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        mul(4'(a), 4'(b), p, lat, nb);
        chk("exh_p", 32'(p), 32'(a * b));
        @(posedge clk);
        #1;
        chk("exh_one_done", 32'(bus.done), 0);
      end
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
